// File: rtl/color_pkg.sv
// Shared constants for the colour classifier: one-hot colour codes,
// default thresholds and the commit-state encoding.
package color_pkg;

  localparam logic [2:0] COLOR_NONE  = 3'b000;
  localparam logic [2:0] COLOR_RED   = 3'b001;
  localparam logic [2:0] COLOR_BLUE  = 3'b010;
  localparam logic [2:0] COLOR_GREEN = 3'b100;

  localparam int unsigned DEF_COUNT_W   = 32;
  localparam int unsigned DEF_RED_MAX   = 24;
  localparam int unsigned DEF_BLUE_MAX  = 21;
  localparam int unsigned DEF_GREEN_MAX = 19;
  localparam int unsigned DEF_STABLE_N  = 3;

  typedef enum logic {
    ST_EMPTY  = 1'b0,
    ST_STABLE = 1'b1
  } state_e;

endpackage

// File: rtl/color_pick.sv
// Stage 1: registered pick of the dominant colour (strict minimum that is
// also under its own threshold); ties or no qualifier give COLOR_NONE.
module color_pick
  import color_pkg::*;
#(
  parameter int unsigned COUNT_W   = DEF_COUNT_W,
  parameter int unsigned RED_MAX   = DEF_RED_MAX,
  parameter int unsigned BLUE_MAX  = DEF_BLUE_MAX,
  parameter int unsigned GREEN_MAX = DEF_GREEN_MAX
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_valid,
  input  logic [COUNT_W-1:0] i_red,
  input  logic [COUNT_W-1:0] i_blue,
  input  logic [COUNT_W-1:0] i_green,
  output logic [2:0]         o_pick,
  output logic               o_valid
);

  localparam logic [COUNT_W-1:0] L_RED_MAX   = COUNT_W'(RED_MAX);
  localparam logic [COUNT_W-1:0] L_BLUE_MAX  = COUNT_W'(BLUE_MAX);
  localparam logic [COUNT_W-1:0] L_GREEN_MAX = COUNT_W'(GREEN_MAX);

  logic [2:0] w_pick;
  logic [2:0] r_pick;
  logic       r_valid;

  // NOTE: assign every always_comb output a default first so no path can infer a latch.
  always_comb begin
    w_pick = COLOR_NONE;
    if (i_red < i_blue && i_red < i_green && i_red < L_RED_MAX)
      w_pick = COLOR_RED;
    else if (i_blue < i_red && i_blue < i_green && i_blue < L_BLUE_MAX)
      w_pick = COLOR_BLUE;
    else if (i_green < i_red && i_green < i_blue && i_green < L_GREEN_MAX)
      w_pick = COLOR_GREEN;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pick  <= COLOR_NONE;
      r_valid <= 1'b0;
    end else begin
      r_valid <= i_valid;
      if (i_valid) r_pick <= w_pick;
    end
  end

  assign o_pick  = r_pick;
  assign o_valid = r_valid;

endmodule

// File: rtl/color_classifier.sv
// Colour classifier top: stage-1 pick, then a debounce counter and a
// two-state commit FSM driving the stable colour and its change strobe.
module color_classifier
  import color_pkg::*;
#(
  parameter int unsigned COUNT_W   = DEF_COUNT_W,
  parameter int unsigned RED_MAX   = DEF_RED_MAX,
  parameter int unsigned BLUE_MAX  = DEF_BLUE_MAX,
  parameter int unsigned GREEN_MAX = DEF_GREEN_MAX,
  parameter int unsigned STABLE_N  = DEF_STABLE_N
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               meas_valid,
  input  logic [COUNT_W-1:0] red_cnt,
  input  logic [COUNT_W-1:0] blue_cnt,
  input  logic [COUNT_W-1:0] green_cnt,
  output logic [2:0]         color,
  output logic               color_valid,
  output logic               color_change,
  output logic [2:0]         pick
);

  localparam logic [3:0] L_STABLE_N = 4'(STABLE_N);

  logic [2:0] w_pick;
  logic       w_pick_vld;
  logic [2:0] w_cand_next;
  logic [3:0] w_agree_next;
  logic       w_commit;
  logic       w_color_valid;
  state_e     w_state_next;

  logic [2:0] r_cand;
  logic [3:0] r_agree;
  logic [2:0] r_color;
  logic       r_color_change;
  state_e     r_state;

  color_pick #(
    .COUNT_W  (COUNT_W),
    .RED_MAX  (RED_MAX),
    .BLUE_MAX (BLUE_MAX),
    .GREEN_MAX(GREEN_MAX)
  ) u_pick (
    .clk    (clk),
    .rst    (rst),
    .i_valid(meas_valid),
    .i_red  (red_cnt),
    .i_blue (blue_cnt),
    .i_green(green_cnt),
    .o_pick (w_pick),
    .o_valid(w_pick_vld)
  );

  // Debounce: a new pick restarts the run at 1; an agreeing pick saturates at STABLE_N.
  always_comb begin
    w_cand_next  = r_cand;
    w_agree_next = r_agree;
    w_commit     = 1'b0;
    if (w_pick_vld) begin
      if (w_pick == r_cand) begin
        if (r_agree < L_STABLE_N) w_agree_next = r_agree + 4'd1;
      end else begin
        w_cand_next  = w_pick;
        w_agree_next = 4'd1;
      end
      w_commit = (w_agree_next == L_STABLE_N);
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_color_valid = 1'b0;
    case (r_state)
      ST_EMPTY:  if (w_commit) w_state_next = ST_STABLE;
      ST_STABLE: w_color_valid = 1'b1;
      default:   w_state_next = ST_EMPTY;
    endcase
  end

  // The colour register holds NONE while EMPTY, so one inequality test covers
  // both the first commit and later changes.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= ST_EMPTY;
      r_cand         <= COLOR_NONE;
      r_agree        <= 4'd0;
      r_color        <= COLOR_NONE;
      r_color_change <= 1'b0;
    end else begin
      r_state        <= w_state_next;
      r_cand         <= w_cand_next;
      r_agree        <= w_agree_next;
      r_color_change <= w_commit && (w_cand_next != r_color);
      if (w_commit) r_color <= w_cand_next;
    end
  end

  assign color        = r_color;
  assign color_valid  = w_color_valid;
  assign color_change = r_color_change;
  assign pick         = w_pick;

endmodule

// File: tb/tb_color_classifier.sv
// Directed bench for color_classifier: table of stage-1 pick vectors plus
// hand-written debounce/commit sequences on a STABLE_N=3 and a STABLE_N=1 build.
module tb_color_classifier;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        meas_valid = 1'b0;
  logic [31:0] red_cnt = '0;
  logic [31:0] blue_cnt = '0;
  logic [31:0] green_cnt = '0;

  logic [2:0] color0, pick0, color1, pick1;
  logic       valid0, change0, valid1, change1;

  int n_cmp  = 0;
  int n_fail = 0;
  int pulses0 = 0;
  int pulses1 = 0;

  always #5 clk = ~clk;

  color_classifier dut0 (
    .clk(clk), .rst(rst), .meas_valid(meas_valid),
    .red_cnt(red_cnt), .blue_cnt(blue_cnt), .green_cnt(green_cnt),
    .color(color0), .color_valid(valid0), .color_change(change0), .pick(pick0)
  );

  color_classifier #(.STABLE_N(1)) dut1 (
    .clk(clk), .rst(rst), .meas_valid(meas_valid),
    .red_cnt(red_cnt), .blue_cnt(blue_cnt), .green_cnt(green_cnt),
    .color(color1), .color_valid(valid1), .color_change(change1), .pick(pick1)
  );

  // Each change pulse lasts one cycle, so it is seen at exactly one rising edge.
  always @(posedge clk) begin
    if (change0) pulses0 <= pulses0 + 1;
    if (change1) pulses1 <= pulses1 + 1;
  end

  typedef struct packed {
    logic [31:0] r;
    logic [31:0] b;
    logic [31:0] g;
    logic [2:0]  pick;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    meas_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Returns on the falling edge after the sampling edge: pick is visible then.
  task automatic strobe(input logic [31:0] r, input logic [31:0] b, input logic [31:0] g);
    @(negedge clk);
    meas_valid = 1'b1;
    red_cnt = r;
    blue_cnt = b;
    green_cnt = g;
    @(negedge clk);
    meas_valid = 1'b0;
  endtask

  vec_t vecs[16];
  int   snap;

  initial begin
    vecs[0]  = '{r: 32'd10,  b: 32'd30, g: 32'd30, pick: 3'b001};
    vecs[1]  = '{r: 32'd30,  b: 32'd3,  g: 32'd30, pick: 3'b010};
    vecs[2]  = '{r: 32'd30,  b: 32'd30, g: 32'd5,  pick: 3'b100};
    vecs[3]  = '{r: 32'd24,  b: 32'd30, g: 32'd30, pick: 3'b000};
    vecs[4]  = '{r: 32'd23,  b: 32'd30, g: 32'd30, pick: 3'b001};
    vecs[5]  = '{r: 32'd10,  b: 32'd10, g: 32'd50, pick: 3'b000};
    vecs[6]  = '{r: 32'd40,  b: 32'd20, g: 32'd20, pick: 3'b000};
    vecs[7]  = '{r: 32'd30,  b: 32'd21, g: 32'd30, pick: 3'b000};
    vecs[8]  = '{r: 32'd30,  b: 32'd20, g: 32'd30, pick: 3'b010};
    vecs[9]  = '{r: 32'd30,  b: 32'd30, g: 32'd19, pick: 3'b000};
    vecs[10] = '{r: 32'd30,  b: 32'd30, g: 32'd18, pick: 3'b100};
    vecs[11] = '{r: 32'd5,   b: 32'd5,  g: 32'd5,  pick: 3'b000};
    vecs[12] = '{r: 32'd0,   b: 32'd1,  g: 32'd2,  pick: 3'b001};
    vecs[13] = '{r: 32'h8000_0000, b: 32'd3, g: 32'd30, pick: 3'b010};
    vecs[14] = '{r: 32'd30,  b: 32'd30, g: 32'd30, pick: 3'b000};
    vecs[15] = '{r: 32'd20,  b: 32'd25, g: 32'd30, pick: 3'b001};

    // Reset state of both builds
    do_reset();
    check("reset color", 32'(color0), 32'd0);
    check("reset valid", 32'(valid0), 32'd0);
    check("reset change", 32'(change0), 32'd0);
    check("reset pick", 32'(pick0), 32'd0);
    check("reset color n1", 32'(color1), 32'd0);
    check("reset valid n1", 32'(valid1), 32'd0);

    // Stage-1 pick table, including threshold and tie edges
    for (int i = 0; i < 16; i++) begin
      strobe(vecs[i].r, vecs[i].b, vecs[i].g);
      check($sformatf("pick vec%0d", i), 32'(pick0), 32'(vecs[i].pick));
    end

    // Three red strobes commit red with one change pulse
    do_reset();
    strobe(10, 30, 30);
    strobe(10, 30, 30);
    strobe(10, 30, 30);
    check("s1 pick", 32'(pick0), 32'd1);
    check("s1 color before commit", 32'(color0), 32'd0);
    check("s1 valid before commit", 32'(valid0), 32'd0);
    @(negedge clk);
    check("s1 color", 32'(color0), 32'd1);
    check("s1 valid", 32'(valid0), 32'd1);
    check("s1 change", 32'(change0), 32'd1);
    @(negedge clk);
    check("s1 change drop", 32'(change0), 32'd0);
    check("s1 color hold", 32'(color0), 32'd1);

    // Interrupted green run does not commit; a fresh run of three does
    snap = pulses0;
    strobe(40, 40, 5);
    strobe(40, 40, 5);
    strobe(10, 30, 30);
    repeat (2) @(negedge clk);
    check("s2 color after g,g,r", 32'(color0), 32'd1);
    check("s2 no pulse", 32'(pulses0 - snap), 32'd0);
    strobe(40, 40, 5);
    strobe(40, 40, 5);
    repeat (2) @(negedge clk);
    check("s2 color after 2 green", 32'(color0), 32'd1);
    strobe(40, 40, 5);
    check("s2 color before commit", 32'(color0), 32'd1);
    @(negedge clk);
    check("s2 color green", 32'(color0), 32'd4);
    check("s2 change", 32'(change0), 32'd1);
    @(negedge clk);
    check("s2 one pulse", 32'(pulses0 - snap), 32'd1);

    // Ties commit NONE from EMPTY without a change pulse
    do_reset();
    snap = pulses0;
    strobe(10, 10, 50);
    strobe(10, 10, 50);
    strobe(10, 10, 50);
    check("s3 pick", 32'(pick0), 32'd0);
    check("s3 valid before commit", 32'(valid0), 32'd0);
    @(negedge clk);
    check("s3 color", 32'(color0), 32'd0);
    check("s3 valid", 32'(valid0), 32'd1);
    check("s3 change", 32'(change0), 32'd0);
    repeat (2) @(negedge clk);
    check("s3 no pulse", 32'(pulses0 - snap), 32'd0);
    check("s3 valid sticky", 32'(valid0), 32'd1);

    // Back-to-back strobes, then reset in the middle of a second burst
    do_reset();
    @(negedge clk);
    meas_valid = 1'b1;
    red_cnt = 30; blue_cnt = 3; green_cnt = 30;
    repeat (2) @(negedge clk);
    @(negedge clk);
    meas_valid = 1'b0;
    check("s5 pick", 32'(pick0), 32'd2);
    check("s5 color before commit", 32'(color0), 32'd0);
    @(negedge clk);
    check("s5 color", 32'(color0), 32'd2);
    check("s5 valid", 32'(valid0), 32'd1);
    check("s5 change", 32'(change0), 32'd1);
    meas_valid = 1'b1;
    red_cnt = 10; blue_cnt = 30; green_cnt = 30;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    meas_valid = 1'b0;
    check("s5 rst color", 32'(color0), 32'd0);
    check("s5 rst valid", 32'(valid0), 32'd0);
    check("s5 rst change", 32'(change0), 32'd0);
    check("s5 rst pick", 32'(pick0), 32'd0);
    repeat (2) @(negedge clk);
    check("s5 post-rst color", 32'(color0), 32'd0);
    check("s5 post-rst valid", 32'(valid0), 32'd0);

    // STABLE_N=1 build: one green strobe commits two cycles later
    do_reset();
    snap = pulses1;
    strobe(30, 30, 5);
    check("s6 pick", 32'(pick1), 32'd4);
    check("s6 color before commit", 32'(color1), 32'd0);
    @(negedge clk);
    check("s6 color", 32'(color1), 32'd4);
    check("s6 valid", 32'(valid1), 32'd1);
    check("s6 change", 32'(change1), 32'd1);
    @(negedge clk);
    check("s6 change drop", 32'(change1), 32'd0);
    @(negedge clk);
    check("s6 one pulse", 32'(pulses1 - snap), 32'd1);
    check("s6 n3 not committed", 32'(color0), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
